// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 4x4 active-low matrix keypad, debounces whole scan
// frames and encodes one accepted key into a 4-bit digit code.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous reset, active low
//   row_n     : raw keypad rows, active low, asynchronous (2-flop synchronised)
//   col_n     : column drive, active low, exactly one bit low
//   key_code  : code of last accepted key, held until next accept
//   key_valid : 1-cycle pulse when a new key is accepted
//   key_down  : level, accepted key currently held
//   multi_err : 1-cycle pulse when >1 key seen in a frame (IDLE/DEBOUNCE only)
module keypad_encoder #(
  parameter int SCAN_CYCLES    = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       multi_err
);

  localparam int SW = $clog2(SCAN_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DB_MAX    = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = 4'h1;  4'b00_01: k = 4'h2;  4'b00_10: k = 4'h3;  4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;  4'b01_01: k = 4'h5;  4'b01_10: k = 4'h6;  4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;  4'b10_01: k = 4'h8;  4'b10_10: k = 4'h9;  4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hE;  4'b11_01: k = 4'h0;  4'b11_10: k = 4'hF;  default:  k = 4'hD;
    endcase
    return k;
  endfunction

  // Frame key count only needs to distinguish 0, 1 and "2 or more".
  function automatic logic [1:0] sat_cnt(input logic [2:0] t);
    return (t >= 3'd2) ? 2'd2 : t[1:0];
  endfunction

  logic [3:0]    row_p0, row_p1;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    col;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_code;
  state_t        state, state_nx;
  logic [3:0]    cand, cand_nx, code_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic          valid_nx, down_nx, merr_nx;

  logic          sample, frame_end;
  logic [2:0]    hits, tot;
  logic [3:0]    hit_code, frame_code;
  logic          f_none, f_one, f_multi;

  assign col_n = ~(4'b0001 << col);

  // Stage p0/p1: row synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_p0 <= 4'b1111;
      row_p1 <= 4'b1111;
    end else begin
      row_p0 <= row_n;
      row_p1 <= row_p0;
    end
  end

  assign sample    = (scan_cnt == SCAN_LAST);
  assign frame_end = sample && (col == 2'd3);

  always_comb begin
    hits     = 3'd0;
    hit_code = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (!row_p1[r]) begin
        hits     = hits + 3'd1;
        hit_code = key_map(2'(r), col);
      end
    end
  end

  // Combine this column with the earlier columns of the same frame.
  assign tot        = {1'b0, acc_cnt} + hits;
  assign frame_code = (acc_cnt != 2'd0) ? acc_code : hit_code;
  assign f_none     = (tot == 3'd0);
  assign f_one      = (tot == 3'd1);
  assign f_multi    = (tot >= 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      col      <= 2'd0;
      acc_cnt  <= 2'd0;
      acc_code <= 4'h0;
    end else begin
      if (sample) begin
        scan_cnt <= '0;
        col      <= col + 2'd1;
        if (frame_end) begin
          acc_cnt  <= 2'd0;
          acc_code <= 4'h0;
        end else begin
          acc_cnt  <= sat_cnt(tot);
          acc_code <= frame_code;
        end
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  // Stage FSM: state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= 4'h0;
      cnt       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cand      <= cand_nx;
      cnt       <= cnt_nx;
      key_code  <= code_nx;
      key_valid <= valid_nx;
      key_down  <= down_nx;
      multi_err <= merr_nx;
    end
  end

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    cnt_nx   = cnt;
    code_nx  = key_code;
    down_nx  = key_down;
    valid_nx = 1'b0;
    merr_nx  = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (f_one) begin
            cand_nx = frame_code;
            if (DEBOUNCE_SCANS == 1) begin
              code_nx  = frame_code;
              valid_nx = 1'b1;
              down_nx  = 1'b1;
              cnt_nx   = '0;
              state_nx = PRESSED;
            end else begin
              cnt_nx   = CW'(1);
              state_nx = DEBOUNCE;
            end
          end else if (f_multi) begin
            merr_nx = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (f_one && (frame_code == cand)) begin
            if (cnt_inc == DB_MAX) begin
              code_nx  = cand;
              valid_nx = 1'b1;
              down_nx  = 1'b1;
              cnt_nx   = '0;
              state_nx = PRESSED;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else begin
            merr_nx  = f_multi;
            cnt_nx   = '0;
            state_nx = IDLE;
          end
        end
        PRESSED: begin
          if (f_none) begin
            if (DEBOUNCE_SCANS == 1) begin
              down_nx  = 1'b0;
              cnt_nx   = '0;
              state_nx = IDLE;
            end else begin
              cnt_nx   = CW'(1);
              state_nx = RELEASE;
            end
          end
        end
        default: begin
          if (f_none) begin
            if (cnt_inc == DB_MAX) begin
              down_nx  = 1'b0;
              cnt_nx   = '0;
              state_nx = IDLE;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else begin
            // Bounce during release: the held key is still the same press.
            cnt_nx   = '0;
            state_nx = PRESSED;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
module tb_keypad_encoder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic        multi_err;

  logic [15:0] keys;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          vcnt  = 0;
  int          mcnt  = 0;
  int          v0, m0;

  keypad_encoder #(.SCAN_CYCLES(4), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down),
    .multi_err(multi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed key shorts its row to its driven (low) column.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
    if (key_valid === 1'b1) vcnt <= vcnt + 1;
    if (multi_err === 1'b1) mcnt <= mcnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align();
    tick(1);
    while (cyc % 16 != 0) tick(1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    keys  = 16'h0;
    rst_n = 1'b0;
    tick(3);
    // 1: reset values and column walk
    chk("rst_col", col_n, 4'b1110);
    chk("rst_code", key_code, 4'h0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_down", key_down, 1'b0);
    chk("rst_merr", multi_err, 1'b0);
    rst_n = 1'b1;
    chk("col0", col_n, 4'b1110);
    tick(4);  chk("col1", col_n, 4'b1101);
    tick(4);  chk("col2", col_n, 4'b1011);
    tick(4);  chk("col3", col_n, 4'b0111);
    tick(4);  chk("col_wrap", col_n, 4'b1110);

    // 2: hold '5' from frame start (cyc 16)
    v0 = vcnt;
    keys = 16'h1 << 5;
    tick(31); chk("k5_early", key_valid, 1'b0);
    tick(1);  chk("k5_valid", key_valid, 1'b1);
    chk("k5_code", key_code, 4'h5);
    chk("k5_down", key_down, 1'b1);
    tick(1);  chk("k5_pulse", key_valid, 1'b0);
    tick(160);
    chk("k5_norepeat", vcnt - v0, 1);
    chk("k5_held", key_down, 1'b1);
    keys = 16'h0;
    align();  chk("k5_rel1", key_down, 1'b1);
    tick(16); chk("k5_rel2", key_down, 1'b0);

    // 3: '8' for one frame only
    v0 = vcnt;
    keys = 16'h1 << 9;
    tick(16);
    keys = 16'h0;
    tick(32);
    chk("k8_novalid", vcnt - v0, 0);
    chk("k8_code", key_code, 4'h5);
    chk("k8_down", key_down, 1'b0);

    // 4: '1' and '3' together
    v0 = vcnt;
    m0 = mcnt;
    keys = (16'h1 << 0) | (16'h1 << 2);
    tick(16); chk("multi_pulse", multi_err, 1'b1);
    tick(1);  chk("multi_low", multi_err, 1'b0);
    tick(32);
    chk("multi_count", mcnt - m0, 3);
    chk("multi_novalid", vcnt - v0, 0);
    keys = 16'h0;

    // 5: accept '#', bounce release, then full release
    align();
    v0 = vcnt;
    keys = 16'h1 << 14;
    tick(32);
    chk("kh_valid", key_valid, 1'b1);
    chk("kh_code", key_code, 4'hF);
    keys = 16'h0;
    tick(16); chk("kh_rel1", key_down, 1'b1);
    keys = 16'h1 << 14;
    tick(16); chk("kh_repress", key_down, 1'b1);
    chk("kh_once", vcnt - v0, 1);
    keys = 16'h0;
    tick(16); chk("kh_relA", key_down, 1'b1);
    tick(16); chk("kh_relB", key_down, 1'b0);

    // 6: reset while '0' is held
    keys = 16'h1 << 13;
    tick(32);
    chk("k0_valid", key_valid, 1'b1);
    chk("k0_down", key_down, 1'b1);
    tick(5);
    rst_n = 1'b0;
    #1;
    chk("k0_rst_down", key_down, 1'b0);
    chk("k0_rst_col", col_n, 4'b1110);
    tick(3);
    rst_n = 1'b1;
    v0 = vcnt;
    tick(31); chk("k0_early", key_valid, 1'b0);
    tick(1);  chk("k0_revalid", key_valid, 1'b1);
    chk("k0_code", key_code, 4'h0);
    chk("k0_redown", key_down, 1'b1);
    tick(2);
    chk("k0_count", vcnt - v0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
